mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit driving the IFU, register file, ALU, data memory and CP0 strobes. It sequences each instruction through FETCH/DCD/EXE/MEM/WB states. It issues `PCWr`, `IRWr` and `NPCSel` to the IFU and consumes the stored instruction the IFU latches. It also takes the interrupt-entry and `eret` decisions.

## Interface
- `OP_NOP_RET` (default 1): unknown opcodes retire as NOP (1); 0 is reserved, not implemented.
- `clk  in  1`  system clock; all state updates on rising edge.
- `reset  in  1`  synchronous, active-high.
- `StoredInstruction  in  32`  IR contents, valid from the cycle after FETCH.
- `zero  in  1`  rs==rt comparator result, valid in DCD.
- `IntReq  in  1`  level interrupt request.
- `PCWr  out  1`  PC write enable.
- `IRWr  out  1`  IR write enable.
- `NPCSel  out  3`  next-PC select:
  - 0 = PC+4
  - 1 = REG_JMP
  - 2 = J_JMP
  - 3 = BEQ_JMP
  - 4 = INT_JMP
- `EPCSel  out  1`  1 routes EPC onto regPC (eret).
- `RegWr  out  1`  register file write enable.
- `RegDst  out  2`  destination register: 0 rt, 1 rd, 2 $31.
- `WDSel  out  2`  write-data source: 0 ALU, 1 memory, 2 PC.
- `ALUSrc  out  1`  1 selects the extended immediate.
- `ExtOp  out  1`  1 sign-extends, 0 zero-extends.
- `ALUOp  out  2`  0 add, 1 sub, 2 or, 3 lui.
- `MemWr  out  1`  data memory write enable.
- `EPCWr  out  1`  EPC write enable.
- `exl  out  1`  exception level flag.
- `state  out  4`  debug view of the state register.

## Operation
- States: FETCH=0, DCD=1, EXE=2, MEM_ADR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, ALU_WB=7, INT=8. Encodings 9–15 are illegal and go to FETCH.
- Outputs are Moore, decoded from `state` plus opcode/funct of `StoredInstruction`. Every enable is 0 in any state that does not list it.
- FETCH: `PCWr=1`, `NPCSel=0`, `IRWr=1`. Always goes to DCD.
- DCD, by opcode/funct:
  - R-type addu (funct 21h), subu (23h), ori (0Dh), lui (0Fh) -> EXE.
  - lw (23h), sw (2Bh) -> MEM_ADR.
  - beq (04h): `PCWr=zero`, `NPCSel=3`, then retire.
  - j (02h): `PCWr=1`, `NPCSel=2`, then retire.
  - jal (03h): as j, plus `RegWr=1`, `RegDst=2`, `WDSel=2`. The PC seen is the already-incremented PC+4.
  - jr (R-type, funct 08h): `PCWr=1`, `NPCSel=1`, `EPCSel=0`, then retire.
  - eret (opcode 10h, funct 18h): `PCWr=1`, `NPCSel=1`, `EPCSel=1`, clear `exl`, then retire.
  - Any other encoding retires as NOP.
- EXE: drives `ALUOp`/`ALUSrc`/`ExtOp`:
  - addu: op 0, src 0.
  - subu: op 1, src 0.
  - ori: op 2, src 1, zero-extend.
  - lui: op 3, src 1.
  - Always goes to ALU_WB.
- ALU_WB: `RegWr=1`, `WDSel=0`; `RegDst=1` for R-type, 0 otherwise. Retires.
- MEM_ADR: `ALUOp=0`, `ALUSrc=1`, `ExtOp=1`. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: holds address controls, then MEM_WB.
- MEM_WB: `RegWr=1`, `RegDst=0`, `WDSel=1`. Retires.
- MEM_WR: `MemWr=1`. Retires.
- Retire means the next state is INT if `IntReq & ~exl`, else FETCH.
- INT: `PCWr=1`, `NPCSel=4`, `EPCWr=1`; EPC captures the current PC, the address of the next unexecuted instruction. Sets `exl`. Goes to FETCH.

## Timing
- Cycle counts:
  - beq / j / jal / jr / eret / NOP: 2 cycles.
  - addu / subu / ori / lui / sw: 4 cycles.
  - lw: 5 cycles.
  - Interrupt entry adds 1 cycle.
- `IntReq` is sampled only on the retire edge. Assertion or deassertion at any other time has no effect. While `exl=1` it is ignored.
- eret retiring with `IntReq=1`: `exl` clears on the same edge the interrupt is evaluated. The decision uses the pre-clear `exl` (=1), so the next state is FETCH; the interrupt is taken at the following retire.
- beq with `zero=0`: PC holds the PC+4 value written in FETCH.
- Reset:
  - While `reset=1`, all enables are forced to 0 combinationally.
  - On the edge: `state<=FETCH`, `exl<=0`.
  - Mid-instruction reset abandons the instruction with no partial writes after the reset edge.
- First FETCH occurs in the first cycle after `reset` falls.

## Test plan
- Reset held 2 cycles, then released with IR=addu -> state 0,1,2,7,0; `PCWr`,`IRWr`=1 only in state 0; `RegWr=1`, `RegDst=1` only in state 7.
- IR=beq (10000004h): `zero=1` -> DCD drives `PCWr=1`, `NPCSel=3`; repeat with `zero=0` -> `PCWr=0`; next state 0 in both cases.
- IR=lw (8C000000h) -> states 0,1,3,4,5,0; `RegWr=1`, `WDSel=1` in state 5. IR=sw (AC000000h) -> `MemWr=1` in state 6 only.
- IR=jal (0C000042h) -> DCD drives `NPCSel=2`, `PCWr=1`, `RegWr=1`, `RegDst=2`, `WDSel=2`.
- `IntReq=1` during an addu -> after state 7 comes state 8 with `NPCSel=4`, `EPCWr=1`; `exl=1`. A second addu with `IntReq` still 1 -> no INT. Then eret (42000018h) -> `EPCSel=1`, `NPCSel=1`; `exl=0` afterward.
- Reset asserted in MEM_RD -> all enables 0 that cycle, state 0 next, `exl=0`, no `RegWr` pulse.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control unit. Steps each instruction through
// FETCH/DCD/EXE/MEM_*/ALU_WB, drives IFU/regfile/ALU/memory/CP0 strobes,
// and takes interrupt entry and eret. Strobes are decoded from the state
// register plus the latched instruction.
module mc_controller #(
  parameter int OP_NOP_RET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] StoredInstruction,
  input  logic        zero,
  input  logic        IntReq,
  output logic        PCWr,
  output logic        IRWr,
  output logic [2:0]  NPCSel,
  output logic        EPCSel,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic [1:0]  ALUOp,
  output logic        MemWr,
  output logic        EPCWr,
  output logic        exl,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DCD = 4'd1, EXE = 4'd2, MEM_ADR = 4'd3, MEM_RD = 4'd4,
    MEM_WB = 4'd5, MEM_WR = 4'd6, ALU_WB = 4'd7, INT = 4'd8
  } state_t;

  state_t state_q, state_d, retire_st;
  logic   exl_q, exl_d;
  logic   pcwr_c, irwr_c, regwr_c, memwr_c, epcwr_c;

  // instruction decode
  logic [5:0] op, fn;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal, is_eret;
  logic       unused_ir;

  assign op        = StoredInstruction[31:26];
  assign fn        = StoredInstruction[5:0];
  assign unused_ir = ^StoredInstruction[25:6];
  assign is_r      = (op == 6'h00);
  assign is_addu   = is_r && (fn == 6'h21);
  assign is_subu   = is_r && (fn == 6'h23);
  assign is_jr     = is_r && (fn == 6'h08);
  assign is_ori    = (op == 6'h0D);
  assign is_lui    = (op == 6'h0F);
  assign is_lw     = (op == 6'h23);
  assign is_sw     = (op == 6'h2B);
  assign is_beq    = (op == 6'h04);
  assign is_j      = (op == 6'h02);
  assign is_jal    = (op == 6'h03);
  assign is_eret   = (op == 6'h10) && (fn == 6'h18);

  // Retiring goes to INT only when a request is pending and exl (pre-update) is clear
  assign retire_st = (IntReq && !exl_q) ? INT : FETCH;

  // next-state and exl update
  always_comb begin
    state_d = FETCH;
    exl_d   = exl_q;
    case (state_q)
      FETCH:   state_d = DCD;
      DCD: begin
        if (is_addu || is_subu || is_ori || is_lui) state_d = EXE;
        else if (is_lw || is_sw)                    state_d = MEM_ADR;
        else if (is_beq || is_j || is_jal || is_jr || is_eret) state_d = retire_st;
        // unknown encodings: retire as NOP; the reserved setting skips the interrupt check
        else if (OP_NOP_RET != 0)                   state_d = retire_st;
        else                                        state_d = FETCH;
        if (is_eret) exl_d = 1'b0;
      end
      EXE:     state_d = ALU_WB;
      MEM_ADR: state_d = is_lw ? MEM_RD : MEM_WR;
      MEM_RD:  state_d = MEM_WB;
      MEM_WB:  state_d = retire_st;
      MEM_WR:  state_d = retire_st;
      ALU_WB:  state_d = retire_st;
      INT: begin
        state_d = FETCH;
        exl_d   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // state and exception-level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exl_q   <= exl_d;
    end
  end

  // Moore strobe decode from state + latched instruction
  always_comb begin
    pcwr_c = 1'b0; irwr_c = 1'b0; regwr_c = 1'b0; memwr_c = 1'b0; epcwr_c = 1'b0;
    NPCSel = 3'd0; EPCSel = 1'b0; RegDst = 2'd0; WDSel = 2'd0;
    ALUSrc = 1'b0; ExtOp = 1'b0; ALUOp = 2'd0;
    case (state_q)
      FETCH: begin
        pcwr_c = 1'b1;
        irwr_c = 1'b1;
      end
      DCD: begin
        if (is_beq) begin
          pcwr_c = zero;
          NPCSel = 3'd3;
        end else if (is_j || is_jal) begin
          pcwr_c = 1'b1;
          NPCSel = 3'd2;
          if (is_jal) begin
            regwr_c = 1'b1;
            RegDst  = 2'd2;
            WDSel   = 2'd2;
          end
        end else if (is_jr || is_eret) begin
          pcwr_c = 1'b1;
          NPCSel = 3'd1;
          EPCSel = is_eret;
        end
      end
      EXE, ALU_WB: begin
        // ALU controls stay up through write-back so the result is stable
        if (is_subu)     ALUOp = 2'd1;
        else if (is_ori) begin ALUOp = 2'd2; ALUSrc = 1'b1; end
        else if (is_lui) begin ALUOp = 2'd3; ALUSrc = 1'b1; end
        if (state_q == ALU_WB) begin
          regwr_c = 1'b1;
          RegDst  = is_r ? 2'd1 : 2'd0;
        end
      end
      MEM_ADR, MEM_RD, MEM_WR: begin
        ALUSrc  = 1'b1;
        ExtOp   = 1'b1;
        memwr_c = (state_q == MEM_WR);
      end
      MEM_WB: begin
        regwr_c = 1'b1;
        WDSel   = 2'd1;
      end
      INT: begin
        pcwr_c  = 1'b1;
        NPCSel  = 3'd4;
        epcwr_c = 1'b1;
      end
      default: ;
    endcase
  end

  // reset kills every write strobe immediately, even mid-instruction
  assign PCWr  = pcwr_c  & ~reset;
  assign IRWr  = irwr_c  & ~reset;
  assign RegWr = regwr_c & ~reset;
  assign MemWr = memwr_c & ~reset;
  assign EPCWr = epcwr_c & ~reset;
  assign exl   = exl_q;
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus process pushes the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_mc_controller;
  logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, IntReq = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        PCWr, IRWr, EPCSel, RegWr, ALUSrc, ExtOp, MemWr, EPCWr, exl;
  logic [2:0]  NPCSel;
  logic [1:0]  RegDst, WDSel, ALUOp;
  logic [3:0]  state;

  mc_controller #(.OP_NOP_RET(1)) dut (
    .clk(clk), .reset(reset), .StoredInstruction(IR), .zero(zero), .IntReq(IntReq),
    .PCWr(PCWr), .IRWr(IRWr), .NPCSel(NPCSel), .EPCSel(EPCSel), .RegWr(RegWr),
    .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .MemWr(MemWr), .EPCWr(EPCWr), .exl(exl), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { string nm; logic [21:0] v; logic [21:0] m; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  // enable groups {PCWr,IRWr,RegWr,MemWr,EPCWr}
  localparam int EN_F = 5'b11000, EN_PC = 5'b10000, EN_RW = 5'b00100;
  localparam int EN_MW = 5'b00010, EN_INT = 5'b10001, EN_JAL = 5'b10100;

  localparam logic [31:0] ADDU = 32'h0000_0021, SUBU = 32'h0000_0023;
  localparam logic [31:0] ORI = 32'h3400_0000, LUI = 32'h3C00_0000;
  localparam logic [31:0] LW = 32'h8C00_0000, SW = 32'hAC00_0000, BEQ = 32'h1000_0004;
  localparam logic [31:0] JAL = 32'h0C00_0042, J = 32'h0800_0010, JR = 32'h03E0_0008;
  localparam logic [31:0] ERET = 32'h4200_0018, NOP = 32'hFC00_0000;

  // monitor: every cycle the DUT presents a control word
  always @(negedge clk) begin
    exp_t e;
    logic [21:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {state, PCWr, IRWr, RegWr, MemWr, EPCWr, exl, NPCSel, EPCSel,
             RegDst, WDSel, ALUSrc, ExtOp, ALUOp};
      checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h want %h (mask %h)", e.nm, act & e.m, e.v & e.m, e.m);
      end
    end
  end

  function automatic void put(inout logic [21:0] v, inout logic [21:0] m,
                              input int pos, input int w, input int x);
    logic [31:0] xv;
    xv = x;
    if (x >= 0)
      for (int b = 0; b < w; b++) begin
        v[pos+b] = xv[b];
        m[pos+b] = 1'b1;
      end
  endfunction

  // push expectation for this cycle (-1 = don't care), then advance one clock
  task automatic cyc(string nm, int st, int en, int ex, int npc = -1, int epc = -1,
                     int rd = -1, int wd = -1, int src = -1, int ext = -1, int aop = -1);
    exp_t e;
    e.nm = nm; e.v = '0; e.m = '0;
    put(e.v, e.m, 18, 4, st);
    put(e.v, e.m, 13, 5, en);
    put(e.v, e.m, 12, 1, ex);
    put(e.v, e.m, 9, 3, npc);
    put(e.v, e.m, 8, 1, epc);
    put(e.v, e.m, 6, 2, rd);
    put(e.v, e.m, 4, 2, wd);
    put(e.v, e.m, 3, 1, src);
    put(e.v, e.m, 2, 1, ext);
    put(e.v, e.m, 0, 2, aop);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch(string nm, logic [31:0] ir, int ex);
    IR = ir;
    cyc({nm, "_F"}, 0, EN_F, ex, 0);
  endtask

  task automatic alu(string nm, logic [31:0] ir, int aop, int src, int ext, int rdst, int ex);
    fetch(nm, ir, ex);
    cyc({nm, "_D"}, 1, 0, ex);
    cyc({nm, "_E"}, 2, 0, ex, -1, -1, -1, -1, src, ext, aop);
    cyc({nm, "_W"}, 7, EN_RW, ex, -1, -1, rdst, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("rst0", 0, 0, 0);
    cyc("rst1", 0, 0, 0);
    reset = 1'b0;

    alu("addu", ADDU, 0, 0, -1, 1, 0);
    alu("subu", SUBU, 1, 0, -1, 1, 0);
    alu("ori",  ORI,  2, 1, 0,  0, 0);
    alu("lui",  LUI,  3, 1, -1, 0, 0);

    zero = 1'b1; fetch("beq1", BEQ, 0); cyc("beq1_D", 1, EN_PC, 0, 3);
    zero = 1'b0; fetch("beq0", BEQ, 0); cyc("beq0_D", 1, 0, 0, 3);

    fetch("lw", LW, 0);
    cyc("lw_D", 1, 0, 0);
    cyc("lw_MA", 3, 0, 0, -1, -1, -1, -1, 1, 1, 0);
    cyc("lw_MR", 4, 0, 0, -1, -1, -1, -1, 1, 1, 0);
    cyc("lw_MW", 5, EN_RW, 0, -1, -1, 0, 1);
    fetch("sw", SW, 0);
    cyc("sw_D", 1, 0, 0);
    cyc("sw_MA", 3, 0, 0, -1, -1, -1, -1, 1, 1, 0);
    cyc("sw_WR", 6, EN_MW, 0);

    fetch("jal", JAL, 0); cyc("jal_D", 1, EN_JAL, 0, 2, -1, 2, 2);
    fetch("j", J, 0);     cyc("j_D", 1, EN_PC, 0, 2);
    fetch("jr", JR, 0);   cyc("jr_D", 1, EN_PC, 0, 1, 0);
    fetch("nop", NOP, 0); cyc("nop_D", 1, 0, 0);

    // request only outside the retire edge: ignored
    fetch("addu_glitch", ADDU, 0);
    cyc("glitch_D", 1, 0, 0);
    IntReq = 1'b1;
    cyc("glitch_E", 2, 0, 0, -1, -1, -1, -1, 0, -1, 0);
    IntReq = 1'b0;
    cyc("glitch_W", 7, EN_RW, 0, -1, -1, 1, 0);

    // interrupt taken after an addu retires
    IntReq = 1'b1;
    alu("addu_int", ADDU, 0, 0, -1, 1, 0);
    cyc("int1", 8, EN_INT, 0, 4);
    // exl masks the still-pending request
    alu("addu_exl", ADDU, 0, 0, -1, 1, 1);
    fetch("eret", ERET, 1);
    cyc("eret_D", 1, EN_PC, 1, 1, 1);
    // retire with exl already clear: interrupt taken again
    fetch("j_int", J, 0);
    cyc("j_int_D", 1, EN_PC, 0, 2);
    IntReq = 1'b0;
    cyc("int2", 8, EN_INT, 0, 4);

    // reset in MEM_RD with exl set
    fetch("lw_rst", LW, 1);
    cyc("lwr_D", 1, 0, 1);
    cyc("lwr_MA", 3, 0, 1);
    reset = 1'b1;
    cyc("lwr_MR_rst", 4, 0, 1);
    reset = 1'b0;
    fetch("after_rst", LW, 0);
    cyc("after_rst_D", 1, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
